// File: rtl/pipelined_write_rx_if.sv
// Link bundle for pipelined_write_rx: 10-bit write bus in, assembled write out.
// master = link driver/consumer side, slave = receiver.
interface pipelined_write_rx_if #(
  parameter int MAX_WR_CYCLES = 4,
  parameter int WR_WIDTH      = 8
);
  localparam int BW = WR_WIDTH + 2;
  localparam int OW = BW * (MAX_WR_CYCLES + 1);

  logic [BW-1:0] wr_bus;
  logic          out_vld;
  logic          out_rdy;
  logic [OW-1:0] out_write;
  logic [2:0]    out_beats;
  logic          wdone;
  logic          err_proto;
  logic          err_ovfl;
  logic          busy;

  modport master (
    output wr_bus, out_rdy,
    input  out_vld, out_write, out_beats,
    input  wdone, err_proto, err_ovfl, busy
  );

  modport slave (
    input  wr_bus, out_rdy,
    output out_vld, out_write, out_beats,
    output wdone, err_proto, err_ovfl, busy
  );
endinterface

// File: rtl/pipelined_write_rx.sv
// Pipelined-write receiver: reassembles cmd + 1..MAX data beats into one
// write held on a valid/ready register, with wdone and error pulses.
// Ports: clk, rst_n (async low), bus (slave): wr_bus, out_rdy in;
//   out_vld, out_write {cmd,dat0..dat3}, out_beats, wdone, err_proto,
//   err_ovfl, busy out.
// Optional: PIPELINED_WRITE_RX_TIMEOUT_EN aborts a write after
//   TIMEOUT_CYC consecutive IDLE cycles.
module pipelined_write_rx #(
  parameter int MAX_WR_CYCLES = 4,
  parameter int WR_WIDTH      = 8,
  parameter int TIMEOUT_CYC   = 16
) (
  input logic                clk,
  input logic                rst_n,
  pipelined_write_rx_if.slave bus
);
  localparam int BW = WR_WIDTH + 2;
  localparam int OW = BW * (MAX_WR_CYCLES + 1);
  localparam int IW = $clog2(MAX_WR_CYCLES);

  typedef enum logic [1:0] {
    CT_IDLE  = 2'd0,
    CT_VALID = 2'd1,
    CT_DONE  = 2'd2,
    CT_RSVD  = 2'd3
  } cycle_type_e;

  typedef enum logic [1:0] {
    WT_STD    = 2'd0,
    WT_MULTI  = 2'd1,
    WT_SINGLE = 2'd2
  } write_type_e;

  typedef enum logic {
    S_IDLE,
    S_DATA
  } state_e;

  state_e                          state_q, state_d;
  logic [BW-1:0]                   cmd_q, cmd_d;
  logic [2:0]                      n_q, n_d;
  logic [2:0]                      cnt_q, cnt_d;
  write_type_e                     wt_q, wt_d;
  logic [MAX_WR_CYCLES-1:0][BW-1:0] slot_q, slot_d;
  logic                            out_vld_q, out_vld_d;
  logic [OW-1:0]                   out_write_q, out_write_d;
  logic [2:0]                      out_beats_q, out_beats_d;
  logic                            wdone_q, wdone_d;
  logic                            err_proto_q, err_proto_d;
  logic                            err_ovfl_q, err_ovfl_d;

  cycle_type_e   ct;
  logic          beat;
  logic          fin;
  logic          last;
  logic [2:0]    cnt_inc;
  logic [OW-1:0] asm_w;

`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_q, idle_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    wt_d        = wt_q;
    slot_d      = slot_q;
    out_vld_d   = out_vld_q;
    out_write_d = out_write_q;
    out_beats_d = out_beats_q;
    wdone_d     = 1'b0;
    err_proto_d = 1'b0;
    err_ovfl_d  = 1'b0;
    beat        = 1'b0;
    fin         = 1'b0;
    last        = 1'b0;
    asm_w       = '0;
    ct          = cycle_type_e'(bus.wr_bus[BW-1 -: 2]);
    cnt_inc     = cnt_q + 3'd1;
`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
    idle_d      = idle_q;
`endif

    if (out_vld_q && bus.out_rdy) out_vld_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.wr_bus[BW-1]) begin
          cmd_d   = bus.wr_bus;
          n_d     = (bus.wr_bus[4:3] == 2'd0) ?
                    3'(MAX_WR_CYCLES) : {1'b0, bus.wr_bus[4:3]};
          cnt_d   = '0;
          slot_d  = '0;
          state_d = S_DATA;
`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
          idle_d  = '0;
`endif
          if (bus.wr_bus[2:0] > 3'd2) begin
            err_proto_d = 1'b1;
            wt_d        = WT_STD;
          end else begin
            wt_d = write_type_e'(bus.wr_bus[1:0]);
          end
        end
      end
      S_DATA: begin
        unique case (1'b1)
          (ct == CT_RSVD):                   err_proto_d = 1'b1;
          (ct == CT_VALID || ct == CT_DONE): beat = 1'b1;
          default: ;
        endcase

        if (beat) begin
          slot_d[cnt_q[IW-1:0]] = bus.wr_bus;
          cnt_d = cnt_inc;
          if (wt_q == WT_MULTI) wdone_d = 1'b1;
          last = (cnt_inc == n_q);
          fin  = (ct == CT_DONE) || last;
          // DONE early or missing DONE on the last beat both complete
          // the write but flag a protocol error.
          if (fin && ((ct == CT_DONE) != last)) err_proto_d = 1'b1;
        end

`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
        idle_d = beat ? '0 : idle_q + TW'(1);
        if (!beat && idle_d == TW'(TIMEOUT_CYC)) begin
          state_d     = S_IDLE;
          err_proto_d = 1'b1;
          idle_d      = '0;
        end
`endif

        if (fin) begin
          state_d = S_IDLE;
          asm_w[OW-1 -: BW] = cmd_q;
          for (int i = 0; i < MAX_WR_CYCLES; i++)
            asm_w[OW-BW*(i+2) +: BW] = slot_d[i];
          // Holding register free (or being drained this cycle): load.
          if (!out_vld_q || bus.out_rdy) begin
            out_vld_d   = 1'b1;
            out_write_d = asm_w;
            out_beats_d = cnt_inc;
            if (wt_q == WT_SINGLE) wdone_d = 1'b1;
          end else begin
            err_ovfl_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      wt_q        <= WT_STD;
      slot_q      <= '0;
      out_vld_q   <= 1'b0;
      out_write_q <= '0;
      out_beats_q <= '0;
      wdone_q     <= 1'b0;
      err_proto_q <= 1'b0;
      err_ovfl_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      wt_q        <= wt_d;
      slot_q      <= slot_d;
      out_vld_q   <= out_vld_d;
      out_write_q <= out_write_d;
      out_beats_q <= out_beats_d;
      wdone_q     <= wdone_d;
      err_proto_q <= err_proto_d;
      err_ovfl_q  <= err_ovfl_d;
    end
  end

`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`endif

  assign bus.out_vld   = out_vld_q;
  assign bus.out_write = out_write_q;
  assign bus.out_beats = out_beats_q;
  assign bus.wdone     = wdone_q;
  assign bus.err_proto = err_proto_q;
  assign bus.err_ovfl  = err_ovfl_q;
  assign bus.busy      = (state_q == S_DATA);
endmodule
